// File: rtl/dbram_be_dp_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: read-during-write
// mode constants, clear-sweep FSM encodings and a constant log2 helper.
package dbram_be_dp_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Clear sweep after reset, then terminal run state.
   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } clr_state_e;

   // Ceiling log2, usable in constant expressions (returns 0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/dbram_be_dp_rd_pipe.sv
// Per-port read return path: turns an accepted read into an rvalid pulse
// READ_LATENCY cycles later. rdat only changes when new data arrives, so it
// holds the last returned word while rvalid is low.
module dbram_rd_pipe #(
   parameter int DATA_WIDTH   = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_acc,
   input  logic [DATA_WIDTH-1:0] rd_word,
   output logic [DATA_WIDTH-1:0] rdat,
   output logic                  rvalid
);

   logic                  vld1_q, vld1_d;
   logic [DATA_WIDTH-1:0] dat1_q, dat1_d;

   // First stage captures the array word on the accept edge.
   always_comb begin
      vld1_d = rd_acc;
      dat1_d = rd_acc ? rd_word : dat1_q;
   end

   // First stage registers; reset drops any read still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld1_q <= 1'b0;
         dat1_q <= '0;
      end else begin
         vld1_q <= vld1_d;
         dat1_q <= dat1_d;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  vld2_q, vld2_d;
      logic [DATA_WIDTH-1:0] dat2_q, dat2_d;

      // Output register stage, loaded only when stage one holds a valid read.
      always_comb begin
         vld2_d = vld1_q;
         dat2_d = vld1_q ? dat1_q : dat2_q;
      end

      // Output register flops.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld2_q <= 1'b0;
            dat2_q <= '0;
         end else begin
            vld2_q <= vld2_d;
            dat2_q <= dat2_d;
         end
      end

      assign rvalid = vld2_q;
      assign rdat   = dat2_q;
   end else begin : g_lat1
      assign rvalid = vld1_q;
      assign rdat   = dat1_q;
   end

endmodule

// File: rtl/dbram_be_dp.sv
// True dual-port byte-enable RAM with req/ack handshake on each port.
// Handshake: a request is accepted on a rising edge where req & ready; ack
// is that product combinationally. Accepted writes update enabled bytes at
// the accept edge; accepted reads return rdat with a one-cycle rvalid pulse
// READ_LATENCY cycles later. Requests while ready is low have no effect.
// After reset the array is zero-swept (unless an init image is in use).
module dbram_be_dp
   import dbram_be_dp_pkg::*;
#(
   parameter int    DATA_WIDTH     = 16,
   parameter int    ADR_WIDTH      = 11,
   parameter int    READ_LATENCY   = 1,
   parameter int    RDW_MODE       = 0,
   parameter int    CLEAR_ON_RESET = 1,
   parameter string INIT_FILE      = "none"
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    ready,
   output logic [15:0]             coll_cnt,
   input  logic                    a_req,
   input  logic                    a_we,
   input  logic [DATA_WIDTH/8-1:0] a_be,
   input  logic [ADR_WIDTH-1:0]    a_adr,
   input  logic [DATA_WIDTH-1:0]   a_wdat,
   output logic                    a_ack,
   output logic [DATA_WIDTH-1:0]   a_rdat,
   output logic                    a_rvalid,
   input  logic                    b_req,
   input  logic                    b_we,
   input  logic [DATA_WIDTH/8-1:0] b_be,
   input  logic [ADR_WIDTH-1:0]    b_adr,
   input  logic [DATA_WIDTH-1:0]   b_wdat,
   output logic                    b_ack,
   output logic [DATA_WIDTH-1:0]   b_rdat,
   output logic                    b_rvalid
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LSB   = clog2(BYTES);
   localparam int IDX_W = ADR_WIDTH - LSB;
   localparam int DEPTH = 2 ** IDX_W;
   // A preloaded image must survive reset, so it suppresses the sweep.
   localparam bit CLEAR_EFF = (CLEAR_ON_RESET != 0) && (INIT_FILE == "none");

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   clr_state_e        state_q, state_d;
   logic [IDX_W-1:0]  clr_adr_q, clr_adr_d;
   logic              clr_we;
   logic [15:0]       coll_cnt_q, coll_cnt_d;

   logic              a_acc, a_wr, a_rd, b_acc, b_wr, b_rd;
   logic [IDX_W-1:0]  a_idx, b_idx;
   logic              same_word, coll;
   logic [DATA_WIDTH-1:0] a_rd_word, b_rd_word;

   assign ready = (state_q == S_RUN);

   assign a_acc = a_req & ready;
   assign b_acc = b_req & ready;
   assign a_wr  = a_acc & a_we;
   assign b_wr  = b_acc & b_we;
   assign a_rd  = a_acc & ~a_we;
   assign b_rd  = b_acc & ~b_we;
   assign a_ack = a_acc;
   assign b_ack = b_acc;

   // Word index drops the byte-offset bits of the address.
   assign a_idx = IDX_W'(a_adr >> LSB);
   assign b_idx = IDX_W'(b_adr >> LSB);

   assign same_word = (a_idx == b_idx);
   assign coll      = a_wr & b_wr & same_word & (|(a_be & b_be));

   // Clear sweep: one zero write per cycle, then run until the next reset.
   always_comb begin
      state_d   = state_q;
      clr_adr_d = clr_adr_q;
      clr_we    = 1'b0;
      case (state_q)
         S_CLEAR: begin
            clr_we = 1'b1;
            if (&clr_adr_q) begin
               state_d = S_RUN;
            end else begin
               clr_adr_d = clr_adr_q + 1'b1;
            end
         end
         S_RUN: begin
            state_d = S_RUN;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   // Saturating count of dual writes that hit the same bytes of one word.
   always_comb begin
      coll_cnt_d = coll_cnt_q;
      if (coll && (coll_cnt_q != 16'hFFFF)) begin
         coll_cnt_d = coll_cnt_q + 16'd1;
      end
   end

   // Control state registers; reset restarts the sweep from word 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CLEAR_EFF ? S_CLEAR : S_RUN;
         clr_adr_q  <= '0;
         coll_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_adr_q  <= clr_adr_d;
         coll_cnt_q <= coll_cnt_d;
      end
   end

   assign coll_cnt = coll_cnt_q;

   // Array writes: B first, then A, so A owns any byte both ports enable.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_adr_q] <= '0;
      end
      for (int i = 0; i < BYTES; i++) begin
         if (b_wr && b_be[i]) mem[b_idx][i*8 +: 8] <= b_wdat[i*8 +: 8];
      end
      for (int i = 0; i < BYTES; i++) begin
         if (a_wr && a_be[i]) mem[a_idx][i*8 +: 8] <= a_wdat[i*8 +: 8];
      end
   end

   // Read words; in new-data mode a same-cycle write from the other port is merged bytewise.
   always_comb begin
      a_rd_word = mem[a_idx];
      b_rd_word = mem[b_idx];
      if ((RDW_MODE == RDW_NEW) && same_word) begin
         for (int i = 0; i < BYTES; i++) begin
            if (b_wr && b_be[i]) a_rd_word[i*8 +: 8] = b_wdat[i*8 +: 8];
            if (a_wr && a_be[i]) b_rd_word[i*8 +: 8] = a_wdat[i*8 +: 8];
         end
      end
   end

   dbram_rd_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe_a (
      .clk    (clk),
      .rst    (rst),
      .rd_acc (a_rd),
      .rd_word(a_rd_word),
      .rdat   (a_rdat),
      .rvalid (a_rvalid)
   );

   dbram_rd_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe_b (
      .clk    (clk),
      .rst    (rst),
      .rd_acc (b_rd),
      .rd_word(b_rd_word),
      .rdat   (b_rdat),
      .rvalid (b_rvalid)
   );

endmodule
